// File: rtl/xy_noc_pkg.sv
// Shared constants for the XY mesh switch: port encoding, header layout,
// arbiter FSM state encoding.
package xy_noc_pkg;

   localparam int SEL_W = 3;

   localparam logic [SEL_W-1:0] PORT_N_IDX = 3'd0;
   localparam logic [SEL_W-1:0] PORT_E_IDX = 3'd1;
   localparam logic [SEL_W-1:0] PORT_S_IDX = 3'd2;
   localparam logic [SEL_W-1:0] PORT_W_IDX = 3'd3;
   localparam logic [SEL_W-1:0] PORT_L_IDX = 3'd4;

   localparam int HDR_Y_LSB = 0;

   // dst_x sits directly above dst_y in the head word
   function automatic int hdr_x_lsb(input int coord_w);
      return coord_w;
   endfunction

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/xy_route_arbiter_if.sv
// Handshake bundle between the switch control unit (master) and the
// route/arbiter block (slave).
interface xy_route_arbiter_if #(
   parameter int PORT_N = 5,
   parameter int DATA_W = 8,
   parameter int SEL_W  = $clog2(PORT_N)
);
   logic [PORT_N-1:0]        vld_input_i;
   logic [PORT_N*DATA_W-1:0] data_i;
   logic [PORT_N-1:0]        wr_en_i;
   logic [SEL_W-1:0]         mux_in_sel_o;
   logic [SEL_W-1:0]         mux_out_sel_o;
   logic                     grant_vld_o;
   logic                     locked_o;

   modport master (
      output vld_input_i, data_i, wr_en_i,
      input  mux_in_sel_o, mux_out_sel_o, grant_vld_o, locked_o
   );

   modport slave (
      input  vld_input_i, data_i, wr_en_i,
      output mux_in_sel_o, mux_out_sel_o, grant_vld_o, locked_o
   );
endinterface

// File: rtl/xy_route_calc.sv
// Combinational XY (X first) output-port computation for one head word.
import xy_noc_pkg::*;

module xy_route_calc #(
   parameter int COORD_W  = 2,
   parameter int ROUTER_X = 0,
   parameter int ROUTER_Y = 0
) (
   input  logic [COORD_W-1:0] i_dst_x,
   input  logic [COORD_W-1:0] i_dst_y,
   output logic [SEL_W-1:0]   o_port
);
   localparam logic [COORD_W-1:0] RX = COORD_W'(ROUTER_X);
   localparam logic [COORD_W-1:0] RY = COORD_W'(ROUTER_Y);

   // "!=" after ">" stands in for "<" so a zero coordinate stays lint-clean
   always_comb begin
      o_port = PORT_L_IDX;
      if (i_dst_x > RX)
         o_port = PORT_E_IDX;
      else if (i_dst_x != RX)
         o_port = PORT_W_IDX;
      else if (i_dst_y > RY)
         o_port = PORT_N_IDX;
      else if (i_dst_y != RY)
         o_port = PORT_S_IDX;
   end
endmodule

// File: rtl/xy_route_arbiter.sv
// Round-robin input arbiter with XY routing for the mesh switch.
// Optional LOCK timeout enabled by defining XY_ARB_TIMEOUT_EN.
import xy_noc_pkg::*;

module xy_route_arbiter #(
   parameter int PORT_N   = 5,
   parameter int DATA_W   = 8,
   parameter int COORD_W  = 2,
   parameter int ROUTER_X = 0,
   parameter int ROUTER_Y = 0,
   parameter int TIMEOUT  = 15
) (
   input  logic                clk_i,
   input  logic                rst_i,
   xy_route_arbiter_if.slave   bus
);
   localparam int X_LSB = hdr_x_lsb(COORD_W);

   arb_state_e       r_state, w_state_n;
   logic [SEL_W-1:0] r_ptr, w_ptr_n;
   logic [SEL_W-1:0] r_sel_in, w_sel_in_n;
   logic [SEL_W-1:0] r_sel_out, w_sel_out_n;
   logic [SEL_W-1:0] w_route [PORT_N];
   logic [SEL_W-1:0] w_win, w_cand, w_win_route;
   logic [SEL_W-1:0] w_mux_in, w_mux_out;
   logic             w_any, w_grant;
   logic             w_unused;

   assign w_unused = ^bus.data_i;

   for (genvar p = 0; p < PORT_N; p++) begin : g_port
      xy_route_calc #(
         .COORD_W (COORD_W),
         .ROUTER_X(ROUTER_X),
         .ROUTER_Y(ROUTER_Y)
      ) u_calc (
         .i_dst_x(bus.data_i[p*DATA_W+X_LSB +: COORD_W]),
         .i_dst_y(bus.data_i[p*DATA_W+HDR_Y_LSB +: COORD_W]),
         .o_port (w_route[p])
      );
   end

   // Scan from the far end so the nearest port after r_ptr wins last
   always_comb begin
      w_win  = '0;
      w_cand = '0;
      for (int k = PORT_N; k >= 1; k--) begin
         w_cand = SEL_W'((int'(r_ptr) + k) % PORT_N);
         if (bus.vld_input_i[w_cand])
            w_win = w_cand;
      end
   end

   assign w_any       = |bus.vld_input_i;
   assign w_win_route = w_route[w_win];

`ifdef XY_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             w_tmo;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_cnt <= '0;
      else if (r_state == ST_LOCK)
         r_cnt <= r_cnt + 1'b1;
      else
         r_cnt <= '0;
   end

   // Leave after exactly TIMEOUT cycles spent in LOCK
   assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
   logic w_tmo;
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      w_state_n   = r_state;
      w_ptr_n     = r_ptr;
      w_sel_in_n  = r_sel_in;
      w_sel_out_n = r_sel_out;
      w_mux_in    = r_sel_in;
      w_mux_out   = r_sel_out;
      w_grant     = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_mux_in  = w_win;
               w_mux_out = w_win_route;
               w_grant   = 1'b1;
               if (bus.wr_en_i[w_win_route]) begin
                  w_ptr_n = w_win;
               end else begin
                  w_sel_in_n  = w_win;
                  w_sel_out_n = w_win_route;
                  w_state_n   = ST_LOCK;
               end
            end
         end
         ST_LOCK: begin
            w_grant = 1'b1;
            if (bus.wr_en_i[r_sel_out] || w_tmo) begin
               w_ptr_n   = r_sel_in;
               w_state_n = ST_IDLE;
            end
         end
         default: w_state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_sel_in  <= '0;
         r_sel_out <= '0;
      end else begin
         r_state   <= w_state_n;
         r_ptr     <= w_ptr_n;
         r_sel_in  <= w_sel_in_n;
         r_sel_out <= w_sel_out_n;
      end
   end

   assign bus.mux_in_sel_o  = w_mux_in;
   assign bus.mux_out_sel_o = w_mux_out;
   assign bus.grant_vld_o   = w_grant;
   assign bus.locked_o      = (r_state == ST_LOCK);

   // The control unit must hold the granted valid until it writes
   a_hold_vld: assert property (
      @(posedge clk_i) disable iff (rst_i)
      (r_state == ST_LOCK) |-> bus.vld_input_i[r_sel_in]
   ) else $error("granted input dropped its valid while locked");

endmodule

// File: tb/tb_xy_route_arbiter.sv
// Directed self-checking bench for xy_route_arbiter at router (1,1).
// Timeout steps run only when XY_ARB_TIMEOUT_EN is defined.
module tb_xy_route_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fails;

   xy_route_arbiter_if #(.PORT_N(5), .DATA_W(8)) bus ();

   xy_route_arbiter #(
      .PORT_N  (5),
      .DATA_W  (8),
      .COORD_W (2),
      .ROUTER_X(1),
      .ROUTER_Y(1),
      .TIMEOUT (15)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int p, input logic [7:0] v);
      bus.data_i[p*8 +: 8] = v;
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst = 1'b1;
      bus.vld_input_i = '0;
      bus.wr_en_i     = '0;
      bus.data_i      = {5{8'h05}};
      #2;
      check("rst_locked", int'(bus.locked_o), 0);
      check("rst_grant", int'(bus.grant_vld_o), 0);
      check("rst_in", int'(bus.mux_in_sel_o), 0);
      check("rst_out", int'(bus.mux_out_sel_o), 0);
      @(negedge clk);
      rst = 1'b0;

      // single local hit on W input
      set_data(3, 8'h05);
      bus.vld_input_i = 5'b01000;
      bus.wr_en_i     = 5'b10000;
      #1;
      check("local_in", int'(bus.mux_in_sel_o), 3);
      check("local_out", int'(bus.mux_out_sel_o), 4);
      check("local_grant", int'(bus.grant_vld_o), 1);
      tick();
      check("local_nolock", int'(bus.locked_o), 0);
      bus.wr_en_i     = '0;
      bus.vld_input_i = 5'b11111;
      #1;
      check("ptr3_win", int'(bus.mux_in_sel_o), 4);

      // X-first routing on Local input
      bus.vld_input_i = 5'b10000;
      set_data(4, 8'h0C);
      #1;
      check("xy_30_in", int'(bus.mux_in_sel_o), 4);
      check("xy_30_E", int'(bus.mux_out_sel_o), 1);
      set_data(4, 8'h07);
      #1;
      check("xy_13_N", int'(bus.mux_out_sel_o), 0);
      set_data(4, 8'h01);
      #1;
      check("xy_01_W", int'(bus.mux_out_sel_o), 3);
      set_data(4, 8'h04);
      #1;
      check("xy_10_S", int'(bus.mux_out_sel_o), 2);

      // move ptr to 4, then fairness over ports 0,2,4
      set_data(4, 8'h05);
      bus.wr_en_i = 5'b11111;
      tick();
      set_data(0, 8'h05);
      set_data(2, 8'h05);
      bus.vld_input_i = 5'b10101;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("fair_order", int'(bus.mux_in_sel_o), (2 * i) % 6);
         tick();
      end
      bus.vld_input_i = '0;

      // blocked output: port 1 to E, wr_en low cycles 0..4
      bus.wr_en_i = '0;
      set_data(1, 8'h09);
      bus.vld_input_i = 5'b00010;
      #1;
      check("blk_c0_in", int'(bus.mux_in_sel_o), 1);
      check("blk_c0_out", int'(bus.mux_out_sel_o), 1);
      check("blk_c0_lock", int'(bus.locked_o), 0);
      tick();
      bus.vld_input_i = 5'b00011;
      for (int c = 1; c < 5; c++) begin
         #1;
         check("blk_locked", int'(bus.locked_o), 1);
         check("blk_in", int'(bus.mux_in_sel_o), 1);
         check("blk_out", int'(bus.mux_out_sel_o), 1);
         tick();
      end
      bus.wr_en_i = 5'b00010;
      #1;
      check("blk_c5_lock", int'(bus.locked_o), 1);
      check("blk_c5_in", int'(bus.mux_in_sel_o), 1);
      check("blk_c5_grant", int'(bus.grant_vld_o), 1);
      tick();
      bus.wr_en_i = '0;
      check("blk_c6_idle", int'(bus.locked_o), 0);
      bus.vld_input_i = 5'b00101;
      #1;
      check("blk_ptr1", int'(bus.mux_in_sel_o), 2);
      bus.vld_input_i = '0;

      // async reset while locked
      set_data(3, 8'h01);
      bus.vld_input_i = 5'b01000;
      #1;
      tick();
      check("rl_locked", int'(bus.locked_o), 1);
      #2;
      rst = 1'b1;
      #1;
      check("rl_unlock", int'(bus.locked_o), 0);
      check("rl_in", int'(bus.mux_in_sel_o), 3);
      check("rl_grant", int'(bus.grant_vld_o), 1);
      bus.vld_input_i = 5'b01010;
      #1;
      check("rl_ptr0", int'(bus.mux_in_sel_o), 1);
      bus.vld_input_i = 5'b01000;
      bus.wr_en_i     = 5'b01000;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rl_regrant_in", int'(bus.mux_in_sel_o), 3);
      check("rl_regrant_out", int'(bus.mux_out_sel_o), 3);
      tick();
      check("rl_done", int'(bus.locked_o), 0);
      bus.wr_en_i     = '0;
      bus.vld_input_i = '0;

`ifdef XY_ARB_TIMEOUT_EN
      // port 4 blocked on E forever, port 0 waiting
      set_data(4, 8'h09);
      set_data(0, 8'h05);
      bus.vld_input_i = 5'b10001;
      #1;
      check("tmo_c0_in", int'(bus.mux_in_sel_o), 4);
      tick();
      for (int c = 1; c < 15; c++) begin
         check("tmo_locked", int'(bus.locked_o), 1);
         tick();
      end
      check("tmo_lock_last", int'(bus.locked_o), 1);
      tick();
      check("tmo_release", int'(bus.locked_o), 0);
      check("tmo_next_win", int'(bus.mux_in_sel_o), 0);
      bus.vld_input_i = '0;
`endif

      #5;
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
